// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM encoding, settings-word layout and reset values.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_e;

    localparam int unsigned DIN_W    = 11;
    localparam int unsigned DIV_W    = 8;
    localparam int unsigned DIV_LSB  = 0;
    localparam int unsigned CPHA_BIT = 8;
    localparam int unsigned CPOL_BIT = 9;
    localparam int unsigned CSEN_BIT = 10;

    localparam logic [DIV_W-1:0] DIV_RESET = 8'd3;

    typedef struct packed {
        logic             cs_en;
        logic             cpol;
        logic             cpha;
        logic [DIV_W-1:0] div;
    } spi_cfg_t;

    localparam spi_cfg_t CFG_RESET = '{cs_en: 1'b0, cpol: 1'b0, cpha: 1'b0, div: DIV_RESET};

    function automatic spi_cfg_t decode_cfg(input logic [DIN_W-1:0] d);
        spi_cfg_t c;
        c.div   = d[DIV_LSB +: DIV_W];
        c.cpha  = d[CPHA_BIT];
        c.cpol  = d[CPOL_BIT];
        c.cs_en = d[CSEN_BIT];
        return c;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SPI half-period timer: emits one leading or trailing edge pulse every div+1 clk cycles
// while enabled, and flags the 16th (final) edge of a byte.
module spi_clkgen
    import spi_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             lead,
    output logic             trail,
    output logic             last
);

    logic [DIV_W-1:0] cnt_q;
    logic [3:0]       edge_q;
    logic             tick;

    assign tick  = en && (cnt_q == div);
    // Even edge indices are leading edges, odd ones trailing.
    assign lead  = tick && !edge_q[0];
    assign trail = tick && edge_q[0];
    assign last  = tick && (edge_q == 4'd15);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q  <= '0;
            edge_q <= '0;
        end else if (tick) begin
            cnt_q  <= '0;
            edge_q <= edge_q + 4'd1;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_core.sv
// Single-byte SPI master with a level-handshake bus port (cmd/wr/rd + ack), programmable
// sclk divider, CPOL/CPHA and chip-select enable.
module spi_core
    import spi_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [DIN_W-1:0] din,
    input  logic             cmd,
    input  logic             wr,
    input  logic             rd,
    output logic [8:0]       dout,
    output logic             ack,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic             cs_n
);

    spi_state_e state_q;
    spi_cfg_t   cfg_q;
    logic       req_q;
    logic       pend_q;
    logic       ack_q;
    logic [8:0] dout_q;
    logic       rx_valid_q;
    logic [7:0] rx_byte_q;
    logic [7:0] tx_q;
    logic [7:0] rx_q;
    logic       sclk_q;
    logic       mosi_q;

    logic req;
    logic acc;
    logic lead;
    logic trail;
    logic last;
    logic sample;
    logic shift_out;

    assign req = cmd | wr | rd;
    // A new or still-pending request is taken in IDLE; reads are taken in any state.
    assign acc = req && (!req_q || pend_q) && ((state_q == IDLE) || rd);

    assign sample    = cfg_q.cpha ? trail : lead;
    assign shift_out = cfg_q.cpha ? lead : trail;

    spi_clkgen u_clkgen (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == SHIFT),
        .div   (cfg_q.div),
        .lead  (lead),
        .trail (trail),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cfg_q      <= CFG_RESET;
            req_q      <= 1'b0;
            pend_q     <= 1'b0;
            ack_q      <= 1'b0;
            dout_q     <= '0;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            req_q  <= req;
            pend_q <= req && !acc && (pend_q || !req_q);

            if (acc) begin
                ack_q <= 1'b1;
            end else if (!req) begin
                ack_q <= 1'b0;
            end

            if (acc && rd) begin
                dout_q     <= {rx_valid_q, rx_byte_q};
                rx_valid_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (acc && cmd) begin
                        cfg_q  <= decode_cfg(din);
                        sclk_q <= din[CPOL_BIT];
                    end else if (acc && wr) begin
                        tx_q    <= din[7:0];
                        rx_q    <= '0;
                        state_q <= SHIFT;
                        if (!cfg_q.cpha) begin
                            mosi_q <= din[7];
                        end
                    end
                end
                SHIFT: begin
                    if (lead || trail) begin
                        sclk_q <= ~sclk_q;
                    end
                    if (sample) begin
                        rx_q <= {rx_q[6:0], miso};
                    end
                    // CPHA=1 presents each bit on its leading edge; CPHA=0 advances to the
                    // next bit on the trailing edge, with nothing left to present after the last.
                    if (shift_out) begin
                        if (cfg_q.cpha) begin
                            mosi_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end else if (!last) begin
                            mosi_q <= tx_q[6];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end
                    end
                    if (last) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    rx_byte_q  <= rx_q;
                    rx_valid_q <= 1'b1;
                    sclk_q     <= cfg_q.cpol;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dout = dout_q;
    assign ack  = ack_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign cs_n = ~cfg_q.cs_en;

endmodule

// File: doc/spi_core.md
SPI_CORE -- requirements
Module: spi_core

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 Port: clk  in  1  system clock.
REQ-003 Port: rst  in  1  synchronous active-high reset.
REQ-004 Port: din  in  11  bus write data; layout set by the request type.
REQ-005 Port: cmd  in  1  settings-write request (level).
REQ-006 Port: wr  in  1  transmit-data request (level).
REQ-007 Port: rd  in  1  receive-data read request (level).
REQ-008 Port: dout  out  9  read data {rx_valid, rx_byte[7:0]}.
REQ-009 Port: ack  out  1  request acknowledge (level).
REQ-010 Ports: sclk out 1 SPI clock; mosi out 1 SPI data out; miso in 1 SPI data in; cs_n out 1 chip select, active-low.

Function
REQ-011 The block SHALL accept a request on the rising edge of req = cmd|wr|rd, detected against a registered copy of req; only one of cmd/wr/rd is high per request.
REQ-012 The block SHALL raise ack on the clk after acceptance and hold it until req falls; ack SHALL drop on the clk after req falls.
REQ-013 A cmd SHALL load cfg: din[7:0]=div, din[8]=cpha, din[9]=cpol, din[10]=cs_en; cs_n = ~cs_en; sclk idles at cpol.
REQ-014 A wr SHALL load din[7:0] into the shift register and start one 8-bit MSB-first transfer; din[10:8] are ignored.
REQ-015 A rd SHALL capture {rx_valid, rx_byte} into dout and clear rx_valid in the same cycle.
REQ-016 A request arriving while state != IDLE SHALL be held pending (ack low) and accepted on the first cycle in IDLE; rd SHALL never stall.
REQ-017 State machine: IDLE -> SHIFT on an accepted wr; SHIFT -> DONE after 16 half-periods; DONE -> IDLE after one clk.
REQ-018 Half-period = div+1 clk cycles (div=0: sclk = clk/2; div=255: clk/512), counted by an 8-bit counter that reloads at each sclk edge.
REQ-019 CPHA=0: MSB on mosi from SHIFT entry; sample miso on the leading edge; shift mosi on the trailing edge.
REQ-020 CPHA=1: shift mosi on the leading edge; sample miso on the trailing edge.
REQ-021 In DONE the block SHALL write the received byte to rx_byte and set rx_valid; a new byte overwrites an unread one.
REQ-022 A cmd SHALL never be applied mid-transfer (held per REQ-016); sclk SHALL return to cpol in DONE.

Reset
REQ-023 On rst: state=IDLE, div=8'd3, cpha=0, cpol=0, cs_en=0, cs_n=1, sclk=0, mosi=0, ack=0, dout=0, rx_valid=0, rx_byte=0, pending request cleared.
REQ-024 rst mid-transfer SHALL abort the transfer with no rx_valid set; sclk returns to 0 on the next clk.

Structure
REQ-025 Package spi_pkg SHALL hold the state encoding (IDLE, SHIFT, DONE), cfg bit positions (DIV_LSB=0, CPHA_BIT=8, CPOL_BIT=9, CSEN_BIT=10) and DIV_RESET=8'd3.
REQ-026 Sub-module spi_clkgen SHALL contain the half-period counter and issue lead/trail edge pulses to the FSM.

Verification
REQ-027 Reset, then cmd with din=11'h400 -> ack 1 clk later; cs_n=0, sclk=0, div=0.
REQ-028 Mode 0, div=0, wr 8'hA5, slave drives 8'h3C -> mosi shows 1010_0101 MSB first, 8 sclk pulses of 2 clk period; rd returns dout=9'h13C, then a second rd returns 9'h03C.
REQ-029 Mode 3 (din=11'h702), wr 8'h81 -> sclk idles 1, half-period 3 clk, mosi changes on falling edges, miso sampled on rising.
REQ-030 wr 8'h55 during an active transfer -> ack stays low until DONE->IDLE, then the second transfer starts; cmd issued mid-transfer -> cfg unchanged until IDLE.
REQ-031 rst asserted at half-period 7 of a transfer -> all outputs at reset values next clk; rd then returns dout=9'h000.
